// File: rtl/unary_dot_accum.sv
// -----------------------------------------------------------------------------
// unary_dot_accum
//
// Receive-side decoder for the unary product fabric. Each cycle the adder tree
// presents a popcount of the product lanes currently emitting a '1'. Summed
// over a run, these counts form the binary dot product. This block integrates
// the counts from launch until the fabric reports completion. A run that never
// completes is cut off after TIMEOUT counted cycles. The result saturates at
// 2^ACC_W-1 and is handed downstream over a valid/ready handshake.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   start        one-cycle launch pulse (coincident with in_rdy to the lanes)
//   count        per-cycle adder-tree sum
//   stream_done  fabric completion, all lanes finished
//   out_valid    result available
//   out_ready    downstream accepts the result
//   out_data     accumulated dot product
//   overflow     result saturated, qualified by out_valid
//   timeout      run ended by the cycle limit, qualified by out_valid
//   busy         high while accumulating or holding a result
// -----------------------------------------------------------------------------
module unary_dot_accum #(
   parameter int NUM_PRODS = 16,
   parameter int TREE_W    = $clog2(NUM_PRODS + 1),
   parameter int ACC_W     = 12,
   parameter int TIMEOUT   = 512,
   parameter int TMR_W     = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TREE_W-1:0] count,
   input  logic              stream_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              overflow,
   output logic              timeout,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               ovf_q, ovf_d;
   logic               tmo_q, tmo_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic [ACC_W:0]     sum;

   // One extra bit of headroom. The tree contributes far less than 2^ACC_W per
   // cycle, so the carry bit alone signals that the true sum passed the
   // maximum.
   assign sum = {1'b0, acc_q} + (ACC_W + 1)'(count);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         timer_q <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         timer_q <= timer_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      timer_d = timer_q;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      valid_d = valid_q;
      busy_d  = busy_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = '0;
               timer_d = '0;
               ovf_d   = 1'b0;
               tmo_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_ACCUM;
            end
         end

         S_ACCUM: begin
            // The final cycle is counted too, whether it ends by completion
            // or by the cycle limit.
            timer_d = timer_q + 1'b1;
            if (sum[ACC_W]) begin
               acc_d = ACC_MAX;
               ovf_d = 1'b1;
            end else begin
               acc_d = sum[ACC_W-1:0];
            end
            if (stream_done) begin
               valid_d = 1'b1;
               state_d = S_HOLD;
            end else if (timer_q == TMR_LAST) begin
               tmo_d   = 1'b1;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            // Result and flags stay frozen until accepted. A start that
            // arrives without acceptance is dropped.
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               if (start) begin
                  // Back-to-back run: the next count arrives the following
                  // cycle.
                  acc_d   = '0;
                  timer_d = '0;
                  ovf_d   = 1'b0;
                  tmo_d   = 1'b0;
                  state_d = S_ACCUM;
               end else begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign out_valid = valid_q;
   assign out_data  = acc_q;
   assign overflow  = ovf_q;
   assign timeout   = tmo_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_unary_dot_accum.sv
module tb_unary_dot_accum;

   localparam int ACC_W  = 12;
   localparam int TREE_W = 5;
   localparam int TMO    = 512;
   localparam int TMO_S  = 8;
   localparam int MAXV   = 4095;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [TREE_W-1:0] count = '0;
   logic              stream_done = 1'b0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [ACC_W-1:0]  out_data;
   logic              overflow;
   logic              timeout;
   logic              busy;

   // Second instance with a short cycle limit for the timeout scenario.
   logic              start_s = 1'b0;
   logic [TREE_W-1:0] count_s = '0;
   logic              stream_done_s = 1'b0;
   logic              out_ready_s = 1'b0;
   logic              out_valid_s;
   logic [ACC_W-1:0]  out_data_s;
   logic              overflow_s;
   logic              timeout_s;
   logic              busy_s;

   always #5 clk = ~clk;

   unary_dot_accum #(.NUM_PRODS(16), .ACC_W(ACC_W), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .stream_done(stream_done), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .overflow(overflow), .timeout(timeout), .busy(busy)
   );

   unary_dot_accum #(.NUM_PRODS(16), .ACC_W(ACC_W), .TIMEOUT(TMO_S)) u_dut_s (
      .clk(clk), .reset(reset), .start(start_s), .count(count_s),
      .stream_done(stream_done_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
      .out_data(out_data_s), .overflow(overflow_s), .timeout(timeout_s), .busy(busy_s)
   );

   typedef struct {
      int data;
      bit ovf;
      bit tmo;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic             stall_q = 1'b0;
   logic [ACC_W-1:0] prev_data_q = '0;
   logic             prev_ovf_q = 1'b0;
   logic             prev_tmo_q = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(prev_data_q));
            check("stall_overflow", int'(overflow), int'(prev_ovf_q));
            check("stall_timeout", int'(timeout), int'(prev_tmo_q));
         end
         stall_q     <= out_valid && !out_ready;
         prev_data_q <= out_data;
         prev_ovf_q  <= overflow;
         prev_tmo_q  <= timeout;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got data %0d, expected no result", out_data);
            end else begin
               $display("result: data=%0d ovf=%0d tmo=%0d (expected %0d %0d %0d)",
                        out_data, overflow, timeout,
                        exp_q[0].data, exp_q[0].ovf, exp_q[0].tmo);
               check("result_data", int'(out_data), exp_q[0].data);
               check("result_overflow", int'(overflow), int'(exp_q[0].ovf));
               check("result_timeout", int'(timeout), int'(exp_q[0].tmo));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Drives a run of n counts (fixed value, or random when rnd=1) with
   // completion on the last one. Runs longer than the limit are cut at TMO
   // cycles without completion. The reference result is the plain total
   // clamped to the maximum.
   task automatic feed(input int n, input bit rnd, input int fixed);
      int  total = 0;
      int  cyc;
      bit  tmo;
      exp_t e;
      tmo = (n > TMO);
      cyc = tmo ? TMO : n;
      for (int i = 0; i < cyc; i++) begin
         count       = rnd ? TREE_W'($urandom_range(0, 16)) : TREE_W'(fixed);
         stream_done = (!tmo && i == cyc - 1);
         total      += int'(count);
         if (i == cyc - 1) begin
            e.data = (total > MAXV) ? MAXV : total;
            e.ovf  = (total > MAXV);
            e.tmo  = tmo;
            exp_q.push_back(e);
         end
         tick();
         if (i < cyc - 1 && (i % 16) == 0)
            check("valid_low_accum", int'(out_valid), 0);
      end
      stream_done = 1'b0;
      count       = TREE_W'($urandom_range(0, 16));
      check("valid_rise", int'(out_valid), 1);
      check("busy_hold", int'(busy), 1);
   endtask

   // Holds the result for `stall` cycles (optionally with start/count noise),
   // then accepts it, optionally with a coincident start.
   task automatic collect(input int stall, input bit b2b, input bit noise);
      for (int s = 0; s < stall; s++) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            count = TREE_W'(7);
            stream_done = 1'($urandom_range(0, 1));
         end
         tick();
      end
      start       = b2b;
      stream_done = 1'b0;
      out_ready   = 1'b1;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      check("after_accept_valid", int'(out_valid), 0);
      check("after_accept_busy", int'(busy), b2b ? 1 : 0);
   endtask

   initial begin
      bit pending;
      tick();
      tick();
      reset = 1'b0;
      check("reset_valid", int'(out_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_data", int'(out_data), 0);
      check("reset_overflow", int'(overflow), 0);
      check("reset_timeout", int'(timeout), 0);

      // Inputs are ignored in IDLE.
      count = TREE_W'(16);
      stream_done = 1'b1;
      tick();
      tick();
      stream_done = 1'b0;
      check("idle_ignore_busy", int'(busy), 0);
      check("idle_ignore_valid", int'(out_valid), 0);

      // Short-limit instance: run of ones that never completes.
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      count_s = TREE_W'(1);
      for (int i = 0; i < TMO_S - 1; i++) tick();
      check("t8_not_yet_valid", int'(out_valid_s), 0);
      tick();
      $display("timeout run: data=%0d tmo=%0d ovf=%0d", out_data_s, timeout_s, overflow_s);
      check("t8_valid", int'(out_valid_s), 1);
      check("t8_data", int'(out_data_s), TMO_S);
      check("t8_timeout", int'(timeout_s), 1);
      check("t8_overflow", int'(overflow_s), 0);
      out_ready_s = 1'b1;
      tick();
      out_ready_s = 1'b0;
      check("t8_idle_valid", int'(out_valid_s), 0);
      check("t8_idle_busy", int'(busy_s), 0);

      // Single lane, 12 ones.
      launch(); feed(12, 1'b0, 1); collect(0, 1'b0, 1'b0);
      // Full array 16 lanes of 15x15.
      launch(); feed(225, 1'b0, 16); collect(1, 1'b0, 1'b0);
      // Saturation.
      launch(); feed(257, 1'b0, 16); collect(0, 1'b0, 1'b0);
      // Backpressure with start/count noise.
      launch(); feed(10, 1'b1, 0); collect(5, 1'b0, 1'b1);
      // Back-to-back.
      launch(); feed(10, 1'b0, 2); collect(2, 1'b1, 1'b0);
      feed(3, 1'b0, 2); collect(0, 1'b0, 1'b0);

      // Mid-run reset.
      launch();
      count = TREE_W'(3);
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_valid", int'(out_valid), 0);
      check("midreset_busy", int'(busy), 0);
      check("midreset_data", int'(out_data), 0);
      launch(); feed(5, 1'b0, 4); collect(0, 1'b0, 1'b0);

      // Limit boundary: completion exactly on the last allowed cycle, then
      // a run that overruns the limit.
      launch(); feed(TMO, 1'b0, 1); collect(0, 1'b0, 1'b0);
      launch(); feed(TMO + 40, 1'b1, 0); collect(1, 1'b0, 1'b0);

      // Random runs with random backpressure and back-to-back launches.
      pending = 1'b0;
      for (int r = 0; r < 20; r++) begin
         bit b;
         if (!pending) launch();
         feed($urandom_range(1, 300), 1'b1, 0);
         b = (r < 19) && ($urandom_range(0, 1) == 1);
         collect($urandom_range(0, 3), b, 1'b1);
         pending = b;
      end

      tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
